mode_counter: RTL
=================

Name: mode_counter

Overview:
Parametrised, configurable up/down counter; successor to the basic increment-only counter.
- Adds programmable modulus, step size, direction, synchronous load, wrap/saturate modes and a one-shot timer mode with a small FSM.
- Used as a general event counter, modulo-N divider and one-shot timer in lab datapaths.

Parameters:
- WIDTH, 8, count register width in bits.
- MAX, 2**WIDTH-1, top count value; counting is modulo MAX+1. Legal range 1..2**WIDTH-1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- dir  in  1  1 = count up, 0 = count down.
- step  in  WIDTH  step amount; a value above MAX is clamped to MAX.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value; a value above MAX is clamped to MAX.
- mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = HOLD.
- start  in  1  one-shot start/restart (ONESHOT only).
- count  out  WIDTH  current count.
- tc  out  1  terminal-count pulse.
- busy  out  1  one-shot running.
- done  out  1  one-shot finished, level.

Behaviour:
- Reset (rst_n low, asynchronous): count = 0, tc = 0, busy = 0, done = 0, FSM = IDLE. Release is synchronous to clk.
- All outputs are registered. A step requested at edge N is visible on count after edge N.
- Priority per cycle: load > start > en step > hold.
- load: count <= min(load_val, MAX); tc = 0 that cycle. FSM state is unchanged, so a one-shot in RUN continues from the loaded value.
- Arithmetic uses a WIDTH+1-bit internal sum; step = 0 leaves count unchanged and tc = 0.
- WRAP, up: count + step > MAX -> count + step - (MAX+1), tc = 1.
- WRAP, down: step > count -> count + (MAX+1) - step, tc = 1.
- SAT, up: clamp to MAX. Down: clamp to 0.
  - tc = 1 only on the step that reaches or crosses the limit.
  - Further steps while held at the limit give tc = 0.
- HOLD: count frozen; en and start are ignored; load still applies.
- tc: high for exactly the one cycle in which the new count is presented; otherwise 0.
- ONESHOT FSM (states IDLE, RUN, DONE):
  - IDLE/DONE + start: count <= 0 if dir = 1, else MAX; go to RUN; busy = 1, done = 0.
  - RUN + en: step per SAT arithmetic. On reaching the limit (MAX if up, 0 if down): count clamps, tc = 1, go to DONE; busy = 0, done = 1.
  - RUN + start: restart as above.
  - DONE: done holds until start (goes to RUN) or mode change (goes to IDLE).
  - In IDLE/DONE, en has no effect.
  - dir is sampled at start and held in a register for the rest of the run.
- Mode change: any mode change while FSM ≠ IDLE sends the FSM to IDLE next cycle. busy and done clear, count holds.
- In non-ONESHOT modes the FSM stays IDLE; busy = done = 0; start is ignored.

Decomposition:
- Package mode_counter_pkg holds:
  - mode_e enum: MODE_WRAP = 2'd0, MODE_SAT = 2'd1, MODE_ONESHOT = 2'd2, MODE_HOLD = 2'd3.
  - state_e enum: IDLE, RUN, DONE.
- Sub-module mode_counter_step: combinational next-value/boundary unit.
  - Inputs: count, step, dir, saturate flag, MAX.
  - Outputs: next count and a crossed flag.
  - Instantiated once; the top keeps the registers and the FSM.

Test Plan:
- Reset: WIDTH=4, MAX=9; drive rst_n low mid-count at count=5 -> count=0, tc=0, busy=0, done=0 immediately, without waiting for a clock edge.
- WRAP up: step=3, en=1, dir=1 from 0 -> 3, 6, 9, 2 (tc=1 on the cycle count=2), then 5. WRAP down: step=4 from 2 -> 8, tc=1.
- SAT: dir=1, step=4 from 0 -> 4, 8, 9 (tc=1), 9 (tc=0). Then dir=0 -> 5, 1, 0 (tc=1), 0 (tc=0).
- Load: load_val=12 with en=1 -> count=9 (clamped), en ignored that cycle. load_val=5 with step=15 (clamped to 9), dir=1 -> 5, 4 (tc=1).
- ONESHOT: mode=2, dir=1, step=4, start pulse -> count=0, busy=1. With en=1 -> 4, 8, 9 (tc=1, done=1, busy=0). Further en leaves count at 9. A start pulse restarts at 0 with busy=1.
- ONESHOT abort: in RUN, switch mode to WRAP -> next cycle busy=0, done=0, count held. Also toggling dir mid-run does not change the counting direction.

Source files
------------

// File: rtl/mode_counter_pkg.sv
// Shared types for the configurable up/down counter: operating modes and one-shot FSM states.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mode_counter_step.sv
// Combinational next-count unit: one wrap/saturate step up or down and the limit-crossing flag.
module mode_counter_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] next,
  output logic             crossed
);

  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] range;
  logic [WIDTH:0] wrap_up;
  logic [WIDTH:0] wrap_dn;

  always_comb begin
    up_sum  = {1'b0, count} + {1'b0, step};
    range   = {1'b0, max} + (WIDTH+1)'(1);
    wrap_up = up_sum - range;
    wrap_dn = {1'b0, count} + range - {1'b0, step};
    next    = count;
    crossed = 1'b0;
    if (dir) begin
      if (sat) begin
        // Reaching the limit counts as crossing, but only when not already parked there.
        if (up_sum >= {1'b0, max}) begin
          next    = max;
          crossed = (count != max);
        end else begin
          next = up_sum[WIDTH-1:0];
        end
      end else if (up_sum > {1'b0, max}) begin
        next    = wrap_up[WIDTH-1:0];
        crossed = 1'b1;
      end else begin
        next = up_sum[WIDTH-1:0];
      end
    end else begin
      if (sat) begin
        if (step >= count) begin
          next    = '0;
          crossed = (count != '0);
        end else begin
          next = count - step;
        end
      end else if (step > count) begin
        next    = wrap_dn[WIDTH-1:0];
        crossed = 1'b1;
      end else begin
        next = count - step;
      end
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Configurable up/down counter with wrap, saturate, hold and one-shot timer modes.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  mode_e            m;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  logic             dir_eff;
  logic             sat;
  logic [WIDTH-1:0] nxt;
  logic             crossed;

  assign m       = mode_e'(mode);
  // A one-shot run keeps the direction captured at start, ignoring later dir changes.
  assign dir_eff = (m == MODE_ONESHOT) ? dir_q : dir;
  assign sat     = (m != MODE_WRAP);

  mode_counter_step #(.WIDTH(WIDTH)) u_step (
    .count   (count_q),
    .step    (clamp_max(step)),
    .dir     (dir_eff),
    .sat     (sat),
    .max     (MAX),
    .next    (nxt),
    .crossed (crossed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    if (m != MODE_ONESHOT) begin
      // Leaving ONESHOT mid-run aborts to IDLE; the count is frozen for that cycle.
      state_d = IDLE;
      if (load) begin
        count_d = clamp_max(load_val);
      end else if (state_q == IDLE && m != MODE_HOLD && en) begin
        count_d = nxt;
        tc_d    = crossed;
      end
    end else begin
      if (load) begin
        count_d = clamp_max(load_val);
      end else if (start) begin
        count_d = dir ? '0 : MAX;
        state_d = RUN;
        dir_d   = dir;
      end else if (state_q == RUN && en) begin
        count_d = nxt;
        tc_d    = crossed;
        if (crossed) state_d = DONE;
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule
